// File: rtl/cache_refill_ctrl_pkg.sv
// Shared defines for the cache refill path.
// Holds the address/word/block geometry, the refill FSM state type and a
// saturating-increment helper for the refill counter.
package cache_refill_ctrl_pkg;

    localparam int unsigned ADDRESS_LEN     = 15;
    localparam int unsigned WORD_LEN        = 32;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned OFFSET_LEN      = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned CACHE_BLOCK_LEN = WORD_LEN * WORDS_PER_BLOCK;
    localparam int unsigned CACHE_INDEX_LEN = ADDRESS_LEN - 1 - OFFSET_LEN;
    localparam int unsigned REFILL_CNT_LEN  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FILL
    } refill_state_t;

    function automatic logic [REFILL_CNT_LEN-1:0] sat_inc(input logic [REFILL_CNT_LEN-1:0] v);
        return (v == '1) ? v : v + REFILL_CNT_LEN'(1);
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Bundle of the refill controller's request, memory and fill signals.
//   req_valid/req_addr/req_ready      : miss request from the cache
//   mem_rd_en/mem_addr                : read strobe and word address to memory
//   mem_rd_valid/mem_rd_data          : returned memory word
//   fill_we/fill_index/fill_tag/
//   fill_data                         : block write into the cache data array
//   refill_cnt                        : saturating count of completed refills
// master = controller side, slave = cache/memory side.
interface cache_refill_ctrl_if #(
    parameter int unsigned ADDRESS_LEN     = cache_refill_ctrl_pkg::ADDRESS_LEN,
    parameter int unsigned WORD_LEN        = cache_refill_ctrl_pkg::WORD_LEN,
    parameter int unsigned WORDS_PER_BLOCK = cache_refill_ctrl_pkg::WORDS_PER_BLOCK
);
    localparam int unsigned INDEX_LEN = ADDRESS_LEN - 1 - $clog2(WORDS_PER_BLOCK);
    localparam int unsigned BLOCK_LEN = WORD_LEN * WORDS_PER_BLOCK;

    logic                   req_valid;
    logic [ADDRESS_LEN-1:0] req_addr;
    logic                   req_ready;
    logic                   mem_rd_en;
    logic [ADDRESS_LEN-1:0] mem_addr;
    logic                   mem_rd_valid;
    logic [WORD_LEN-1:0]    mem_rd_data;
    logic                   fill_we;
    logic [INDEX_LEN-1:0]   fill_index;
    logic                   fill_tag;
    logic [BLOCK_LEN-1:0]   fill_data;
    logic [15:0]            refill_cnt;

    modport master (
        input  req_valid, req_addr, mem_rd_valid, mem_rd_data,
        output req_ready, mem_rd_en, mem_addr, fill_we, fill_index, fill_tag,
               fill_data, refill_cnt
    );

    modport slave (
        output req_valid, req_addr, mem_rd_valid, mem_rd_data,
        input  req_ready, mem_rd_en, mem_addr, fill_we, fill_index, fill_tag,
               fill_data, refill_cnt
    );

endinterface

// File: rtl/cache_refill_ctrl_block_assembler.sv
// Cache block assembly register.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears the block)
//   lane_we    : write lane_data into lane lane_sel this cycle
//   lane_sel   : lane (word offset) to write
//   lane_data  : word to write
//   block      : assembled block, lane k at bits [k*WORD_LEN +: WORD_LEN]
module block_assembler #(
    parameter int unsigned WORD_LEN        = cache_refill_ctrl_pkg::WORD_LEN,
    parameter int unsigned WORDS_PER_BLOCK = cache_refill_ctrl_pkg::WORDS_PER_BLOCK,
    parameter int unsigned LANE_SEL_LEN    = $clog2(WORDS_PER_BLOCK)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                lane_we,
    input  logic [LANE_SEL_LEN-1:0]             lane_sel,
    input  logic [WORD_LEN-1:0]                 lane_data,
    output logic [WORD_LEN*WORDS_PER_BLOCK-1:0] block
);

    always_ff @(posedge clk) begin
        if (rst) begin
            block <= '0;
        end else begin
            for (int unsigned k = 0; k < WORDS_PER_BLOCK; k++) begin
                if (lane_we && (lane_sel == LANE_SEL_LEN'(k))) begin
                    block[k*WORD_LEN +: WORD_LEN] <= lane_data;
                end
            end
        end
    end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller.
// Accepts a miss address, fetches the containing block from main memory one
// word at a time (offsets in ascending order, one outstanding read), then
// writes the assembled block into the cache in a single fill cycle.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset
//   bus  : request / memory / fill signals (cache_refill_ctrl_if.master)
module cache_refill_ctrl #(
    parameter int unsigned ADDRESS_LEN     = cache_refill_ctrl_pkg::ADDRESS_LEN,
    parameter int unsigned WORD_LEN        = cache_refill_ctrl_pkg::WORD_LEN,
    parameter int unsigned WORDS_PER_BLOCK = cache_refill_ctrl_pkg::WORDS_PER_BLOCK
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_refill_ctrl_if.master  bus
);
    import cache_refill_ctrl_pkg::*;

    localparam int unsigned OFF_LEN  = $clog2(WORDS_PER_BLOCK);
    localparam int unsigned BASE_LEN = ADDRESS_LEN - OFF_LEN;
    localparam int unsigned IDX_LEN  = BASE_LEN - 1;
    localparam int unsigned BLK_LEN  = WORD_LEN * WORDS_PER_BLOCK;

    refill_state_t           state;
    // Only the block-aligned part of the base address is stored; its offset
    // bits are zero by construction.
    logic [BASE_LEN-1:0]     base_blk;
    logic [OFF_LEN-1:0]      word_cnt;
    logic [OFF_LEN-1:0]      next_cnt;
    logic                    ready_q;
    logic                    rd_en_q;
    logic [ADDRESS_LEN-1:0]  mem_addr_q;
    logic                    fill_we_q;
    logic [15:0]             refill_cnt_q;
    logic                    lane_we;
    logic [BLK_LEN-1:0]      block;
    logic                    last_word;
    logic                    unused_addr_bits;

    assign next_cnt         = word_cnt + OFF_LEN'(1);
    assign last_word        = (word_cnt == OFF_LEN'(WORDS_PER_BLOCK - 1));
    assign unused_addr_bits = ^bus.req_addr[OFF_LEN-1:0];

    // Data is captured only in WAIT; returns in any other state are dropped.
    assign lane_we = (state == ST_WAIT) && bus.mem_rd_valid;

    block_assembler #(
        .WORD_LEN        (WORD_LEN),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK)
    ) u_block_assembler (
        .clk       (clk),
        .rst       (rst),
        .lane_we   (lane_we),
        .lane_sel  (word_cnt),
        .lane_data (bus.mem_rd_data),
        .block     (block)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            base_blk     <= '0;
            word_cnt     <= '0;
            ready_q      <= 1'b1;
            rd_en_q      <= 1'b0;
            mem_addr_q   <= '0;
            fill_we_q    <= 1'b0;
            refill_cnt_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        base_blk   <= bus.req_addr[ADDRESS_LEN-1:OFF_LEN];
                        word_cnt   <= '0;
                        ready_q    <= 1'b0;
                        rd_en_q    <= 1'b1;
                        mem_addr_q <= {bus.req_addr[ADDRESS_LEN-1:OFF_LEN], {OFF_LEN{1'b0}}};
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rd_en_q    <= 1'b0;
                    mem_addr_q <= '0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.mem_rd_valid) begin
                        if (last_word) begin
                            fill_we_q <= 1'b1;
                            state     <= ST_FILL;
                        end else begin
                            word_cnt   <= next_cnt;
                            rd_en_q    <= 1'b1;
                            mem_addr_q <= {base_blk, next_cnt};
                            state      <= ST_ISSUE;
                        end
                    end
                end
                ST_FILL: begin
                    fill_we_q    <= 1'b0;
                    refill_cnt_q <= sat_inc(refill_cnt_q);
                    ready_q      <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.mem_rd_en  = rd_en_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.fill_we    = fill_we_q;
    assign bus.fill_index = base_blk[IDX_LEN-1:0];
    assign bus.fill_tag   = base_blk[BASE_LEN-1];
    assign bus.fill_data  = block;
    assign bus.refill_cnt = refill_cnt_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Testbench for cache_refill_ctrl: randomized memory latency, addresses and
// stray returns, checked every cycle against a transaction-level model, plus
// directed scenarios with literal expectations.
module tb_cache_refill_ctrl;

    localparam int unsigned AL  = 15;
    localparam int unsigned WL  = 32;
    localparam int unsigned WPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cache_refill_ctrl_if #(.ADDRESS_LEN(AL), .WORD_LEN(WL), .WORDS_PER_BLOCK(WPB)) bus ();

    cache_refill_ctrl #(.ADDRESS_LEN(AL), .WORD_LEN(WL), .WORDS_PER_BLOCK(WPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Stimulus controls (written by main only)
    int lat_min = 1, lat_max = 1;
    bit directed = 1'b1;
    bit stray_en = 1'b0;
    int preset_req = 0;

    // Memory responder: answers each read strobe after a latency of L cycles,
    // optionally injecting stray DEAD returns while no read is pending.
    initial begin : responder
        bit pending;
        int countdown;
        logic [31:0] rdata;
        pending = 1'b0;
        countdown = 0;
        rdata = '0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_rd_valid = 1'b0;
            bus.mem_rd_data  = '0;
            if (pending) begin
                if (countdown <= 1) begin
                    bus.mem_rd_valid = 1'b1;
                    bus.mem_rd_data  = rdata;
                    pending = 1'b0;
                end else begin
                    countdown--;
                end
            end else if (stray_en && ($urandom_range(0, 3) == 0)) begin
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_data  = 32'hDEAD;
            end
            @(negedge clk);
            if (bus.mem_rd_en) begin
                pending   = 1'b1;
                countdown = $urandom_range(lat_min, lat_max);
                rdata     = directed ? (32'h0000_00A0 + {30'b0, bus.mem_addr[1:0]}) : $urandom;
            end
        end
    end

    // Transaction-level model: a refill is a base address plus a schedule of
    // when the next read strobe and the fill strobe are due.
    int cyc = 0;
    bit rst_seen = 1'b0;
    bit m_busy = 1'b0;
    logic [14:0] m_base = '0;
    int m_words = 0;
    int m_issue_at = -1;
    int m_fill_at = -1;
    logic [15:0] m_cnt = '0;
    logic [31:0] m_lanes [4];
    int preset_seen = 0;
    int accept_count = 0, fill_count = 0, rd_count = 0;
    int last_accept_cyc = 0, last_fill_cyc = 0;
    logic [14:0] rd_addr_q [$];

    initial for (int i = 0; i < 4; i++) m_lanes[i] = '0;

    always @(negedge clk) begin : compare
        bit exp_rd;
        logic [14:0] exp_addr;
        if (preset_req != preset_seen) begin
            m_cnt = 16'hFFFE;
            preset_seen = preset_req;
        end
        if (rst_seen) begin
            exp_rd   = m_busy && (m_issue_at == cyc);
            exp_addr = exp_rd ? (m_base + 15'(m_words)) : 15'd0;
            chk("req_ready",  bus.req_ready, !m_busy);
            chk("mem_rd_en",  bus.mem_rd_en, exp_rd);
            chk("mem_addr",   bus.mem_addr, exp_addr);
            chk("fill_we",    bus.fill_we, m_busy && (m_fill_at == cyc));
            chk("fill_index", bus.fill_index, m_base[13:2]);
            chk("fill_tag",   bus.fill_tag, m_base[14]);
            chk("fill_data",  bus.fill_data, {m_lanes[3], m_lanes[2], m_lanes[1], m_lanes[0]});
            chk("refill_cnt", bus.refill_cnt, m_cnt);
        end
        if (bus.mem_rd_en) begin
            rd_count++;
            rd_addr_q.push_back(bus.mem_addr);
        end
        if (bus.fill_we) begin
            fill_count++;
            last_fill_cyc = cyc;
        end
        if (rst) begin
            rst_seen = 1'b1;
            m_busy = 1'b0;
            m_base = '0;
            m_words = 0;
            m_issue_at = -1;
            m_fill_at = -1;
            m_cnt = '0;
            for (int i = 0; i < 4; i++) m_lanes[i] = '0;
        end else if (!m_busy) begin
            if (bus.req_valid) begin
                m_busy = 1'b1;
                m_base = {bus.req_addr[14:2], 2'b00};
                m_words = 0;
                m_issue_at = cyc + 1;
                accept_count++;
                last_accept_cyc = cyc;
            end
        end else if (m_fill_at == cyc) begin
            m_busy = 1'b0;
            m_fill_at = -1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (m_issue_at != -1 && cyc > m_issue_at && bus.mem_rd_valid) begin
            m_lanes[m_words] = bus.mem_rd_data;
            if (m_words == 3) begin
                m_fill_at = cyc + 1;
                m_issue_at = -1;
            end else begin
                m_words++;
                m_issue_at = cyc + 1;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [14:0] a);
        int a0;
        a0 = accept_count;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        for (int n = 0; n < 50 && accept_count == a0; n++) tick();
        bus.req_valid = 1'b0;
        if (accept_count == a0) timeout_fail("accept");
    endtask

    task automatic wait_fill();
        int f0;
        f0 = fill_count;
        for (int n = 0; n < 300 && fill_count == f0; n++) tick();
        if (fill_count == f0) timeout_fail("fill");
    endtask

    localparam logic [127:0] PATTERN = 128'h000000A3_000000A2_000000A1_000000A0;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int a_cyc, r0, f0, r1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("reset req_ready",  bus.req_ready, 1'b1);
        chk("reset refill_cnt", bus.refill_cnt, 16'h0);
        chk("reset fill_data",  bus.fill_data, 128'h0);
        chk("reset mem_rd_en",  bus.mem_rd_en, 1'b0);
        chk("reset fill_we",    bus.fill_we, 1'b0);

        // Directed refill of 0x4006 with 1-cycle memory
        r0 = rd_addr_q.size();
        request(15'h4006);
        a_cyc = last_accept_cyc;
        wait_fill();
        chk("latency accept->fill", 32'(last_fill_cyc - a_cyc), 32'd9);
        chk("rd count", 32'(rd_addr_q.size() - r0), 32'd4);
        for (int k = 0; k < 4; k++)
            if (rd_addr_q.size() > r0 + k) chk("rd addr order", rd_addr_q[r0 + k], 15'h4004 + 15'(k));
        chk("directed fill_data",  bus.fill_data, PATTERN);
        chk("directed fill_index", bus.fill_index, 12'h001);
        chk("directed fill_tag",   bus.fill_tag, 1'b1);
        chk("directed refill_cnt", bus.refill_cnt, 16'd1);

        // 5-cycle memory latency
        lat_min = 5; lat_max = 5;
        r0 = rd_count; f0 = fill_count;
        request(15'($urandom));
        wait_fill();
        repeat (3) tick();
        chk("slow mem rd pulses", 32'(rd_count - r0), 32'd4);
        chk("slow mem fill pulses", 32'(fill_count - f0), 32'd1);

        // req_valid held, address churning during the refill
        lat_min = 1; lat_max = 1; directed = 1'b0;
        f0 = fill_count;
        bus.req_valid = 1'b1;
        bus.req_addr  = 15'h1111;
        for (int n = 0; n < 100 && fill_count == f0; n++) begin
            tick();
            bus.req_addr = 15'($urandom);
        end
        if (fill_count == f0) timeout_fail("held fill");
        bus.req_addr = 15'h2A57;
        r1 = rd_count;
        tick();
        bus.req_valid = 1'b0;
        chk("back-to-back accept gap", 32'(last_accept_cyc - last_fill_cyc), 32'd1);
        wait_fill();
        if (rd_addr_q.size() > r1) chk("second refill base", rd_addr_q[r1], 15'h2A54);
        else timeout_fail("second refill read");

        // Stray returns in IDLE and ISSUE are ignored
        directed = 1'b1; stray_en = 1'b1;
        repeat (10) tick();
        request(15'h0123);
        wait_fill();
        stray_en = 1'b0;
        chk("stray fill_data", bus.fill_data, PATTERN);
        chk("stray fill_index", bus.fill_index, 12'h048);

        // Reset after two words: block abandoned, next refill from word 0
        f0 = fill_count;
        request(15'h7FFB);
        for (int n = 0; n < 50 && m_words != 2; n++) tick();
        if (m_words != 2) timeout_fail("two words");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("abandoned fill count", 32'(fill_count - f0), 32'd0);
        chk("abandoned refill_cnt", bus.refill_cnt, 16'd0);
        r0 = rd_addr_q.size();
        request(15'h2345);
        wait_fill();
        if (rd_addr_q.size() > r0) chk("post-reset first read", rd_addr_q[r0], 15'h2344);
        chk("post-reset fill_data",  bus.fill_data, PATTERN);
        chk("post-reset fill_index", bus.fill_index, 12'h8D1);
        chk("post-reset fill_tag",   bus.fill_tag, 1'b0);
        chk("post-reset refill_cnt", bus.refill_cnt, 16'd1);

        // Randomized refills
        directed = 1'b0; stray_en = 1'b1; lat_min = 1; lat_max = 6;
        for (int t = 0; t < 25; t++) begin
            repeat ($urandom_range(0, 3)) tick();
            request(15'($urandom));
            wait_fill();
        end
        stray_en = 1'b0; lat_max = 2;
        repeat (8) tick();

        // Saturation of the refill counter
        force dut.refill_cnt_q = 16'hFFFE;
        preset_req++;
        tick();
        release dut.refill_cnt_q;
        tick();
        chk("preset refill_cnt", bus.refill_cnt, 16'hFFFE);
        for (int t = 0; t < 3; t++) begin
            request(15'($urandom));
            wait_fill();
            chk("saturated refill_cnt", bus.refill_cnt, 16'hFFFF);
        end

        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter ADDRESS_LEN, default 15: word-address width; bit 14 = tag, bits 13:2 = index, bits 1:0 = word offset.
REQ-002 Parameter WORD_LEN, default 32: main-memory word width.
REQ-003 Parameter WORDS_PER_BLOCK, default 4: words per cache block; block width = WORDS_PER_BLOCK*WORD_LEN = 128.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  cache reports a miss and requests a refill.
REQ-007 req_addr  input  ADDRESS_LEN  word address of the missing access.
REQ-008 req_ready  output  1  controller idle; a refill request is accepted this cycle.
REQ-009 mem_rd_en  output  1  one-cycle read strobe to main memory.
REQ-010 mem_addr  output  ADDRESS_LEN  main-memory word address; valid while mem_rd_en=1.
REQ-011 mem_rd_valid  input  1  main memory returns mem_rd_data this cycle.
REQ-012 mem_rd_data  input  WORD_LEN  returned word.
REQ-013 fill_we  output  1  one-cycle write strobe into the cache data array.
REQ-014 fill_index  output  12  cache line index to write.
REQ-015 fill_tag  output  1  tag bit stored with the line; the cache sets valid=1 on fill_we.
REQ-016 fill_data  output  128  assembled block; lane k (bits 32k+31:32k) = word at offset k.
REQ-017 refill_cnt  output  16  completed refills, saturating at 16'hFFFF.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, FILL; req_ready=1 only in IDLE.
REQ-019 IDLE: when req_valid=1, latch base address = req_addr with bits 1:0 forced to 0, clear word counter, go to ISSUE.
REQ-020 ISSUE: mem_rd_en=1 for exactly one cycle with mem_addr = base + word counter; go to WAIT.
REQ-021 WAIT: on mem_rd_valid=1, write mem_rd_data into lane word counter; if counter = WORDS_PER_BLOCK-1, go to FILL, else increment counter and go to ISSUE; stay in WAIT indefinitely otherwise (no timeout).
REQ-022 FILL: fill_we=1 for exactly one cycle, fill_index = base[13:2], fill_tag = base[14], fill_data complete; increment refill_cnt (saturating); go to IDLE.
REQ-023 Words are fetched in ascending offset order 0,1,2,3 regardless of the missing word's offset.
REQ-024 Single outstanding memory read: mem_rd_en never asserts while in WAIT.
REQ-025 mem_rd_valid outside WAIT is ignored; it changes neither the data lanes nor the state.
REQ-026 req_valid while not in IDLE is ignored; no queuing, and latched address is unchanged.
REQ-027 mem_rd_valid in the same cycle as the ISSUE-to-WAIT transition is not captured; capture starts in the first WAIT cycle.
REQ-028 With memory answering one cycle after mem_rd_en, request accept to fill_we = 9 cycles (IDLE 1, 4×(ISSUE+WAIT), FILL).
REQ-029 fill_index, fill_tag and fill_data hold their values after FILL until the next accepted request.
REQ-030 mem_addr = 0 whenever mem_rd_en=0.

Reset
REQ-031 rst=1 at a rising edge forces IDLE, word counter 0, base 0, fill_data 0, refill_cnt 0, mem_rd_en 0, fill_we 0; req_ready=1 the cycle after.
REQ-032 Reset mid-refill abandons the block; no fill_we is generated for it, and late mem_rd_valid is ignored under REQ-025.

Structure
REQ-033 ADDRESS_LEN, WORD_LEN, CACHE_BLOCK_LEN (128), CACHE_INDEX_LEN (12) and the FSM state enum belong in the shared defines package used by the cache.
REQ-034 Single module; the 128-bit block assembly register with lane write-enable is a natural sub-module, block_assembler.

Verification
REQ-035 Reset, then req_valid with req_addr=15'h4006, 1-cycle memory returning 32'hA0..A3 -> mem_addr 4004,4005,4006,4007; fill_we after 9 cycles; fill_index=12'h001, fill_tag=1, fill_data=128'h000000A3_000000A2_000000A1_000000A0; refill_cnt=1.
REQ-036 Memory latency 5 cycles per word -> exactly 4 mem_rd_en pulses, none during WAIT; fill_we once.
REQ-037 req_valid held high and req_addr changed during refill -> second address ignored until IDLE; next refill starts in the cycle after FILL.
REQ-038 Stray mem_rd_valid=1 (data 32'hDEAD) in IDLE and ISSUE -> no lane change, no state change.
REQ-039 rst asserted after two words are returned -> no fill_we; refill_cnt=0; the next request refills correctly from word 0.
REQ-040 Force refill_cnt to 16'hFFFE, perform 3 refills -> refill_cnt reads 16'hFFFF and stays there.
